// File: rtl/red_pitaya_relock_sweep.sv
// Relock controller: watches a lock-quality monitor, and after losing lock drives a
// triangle/sawtooth sweep until lock returns. Optional HOLDOFF stage under RELOCK_HOLDOFF_EN.
module red_pitaya_relock_sweep #(
    parameter int DW   = 14,
    parameter int RW   = 12,
    parameter int SW   = 24,
    parameter int MODE = 0
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 enable_i,
    input  logic [RW-1:0]        relock_i,
    input  logic [RW-1:0]        win_min_i,
    input  logic [RW-1:0]        win_max_i,
    input  logic [15:0]          holdoff_i,
    input  logic [SW-1:0]        step_i,
    input  logic signed [DW-1:0] out_lo_i,
    input  logic signed [DW-1:0] out_hi_i,
    input  logic [1:0]           railed_i,
    output logic signed [DW-1:0] sweep_o,
    output logic                 sweep_act_o,
    output logic                 int_rst_o,
    output logic [1:0]           state_o,
    output logic [15:0]          relock_cnt_o
);

    localparam int AW = DW + SW;
    localparam int XW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_SWEEP   = 2'd3
    } state_t;

`ifdef RELOCK_HOLDOFF_EN
    localparam state_t OOL_STATE = ST_HOLDOFF;
    logic [15:0] hold_q, hold_d;
`else
    localparam state_t OOL_STATE = ST_SWEEP;
    logic unused_holdoff;
    assign unused_holdoff = ^holdoff_i;
`endif

    state_t               state_q, state_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 up_q, up_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 act_q, act_d;
    logic                 rst_q, rst_d;

    logic                 in_lock;
    logic signed [XW-1:0] lo_x, hi_x, acc_x, step_x, sum_x, dif_x;

    assign in_lock = (relock_i >= win_min_i) && (relock_i <= win_max_i) && (railed_i == 2'b00);

    // One spare MSB keeps acc +/- step from wrapping before the clamp compares it.
    assign lo_x   = {out_lo_i[DW-1], out_lo_i, {SW{1'b0}}};
    assign hi_x   = {out_hi_i[DW-1], out_hi_i, {SW{1'b0}}};
    assign acc_x  = {acc_q[AW-1], acc_q};
    assign step_x = {{(DW+1){1'b0}}, step_i};
    assign sum_x  = acc_x + step_x;
    assign dif_x  = acc_x - step_x;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = in_lock ? ST_LOCKED : OOL_STATE;
                ST_LOCKED: if (!in_lock) state_d = OOL_STATE;
`ifdef RELOCK_HOLDOFF_EN
                ST_HOLDOFF: begin
                    if (in_lock)                     state_d = ST_LOCKED;
                    else if (hold_q == holdoff_i)    state_d = ST_SWEEP;
                end
`endif
                ST_SWEEP:  if (in_lock) state_d = ST_LOCKED;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        acc_d = acc_q;
        up_d  = up_q;
        cnt_d = cnt_q;
        act_d = (state_d == ST_SWEEP);
        rst_d = 1'b0;
`ifdef RELOCK_HOLDOFF_EN
        hold_d = hold_q;
        if (state_d == ST_HOLDOFF) hold_d = (state_q == ST_HOLDOFF) ? hold_q + 16'd1 : 16'd0;
`endif
        if (state_d == ST_SWEEP && state_q != ST_SWEEP) begin
            acc_d = lo_x[AW-1:0];
            up_d  = 1'b1;
            rst_d = 1'b1;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end else if (state_q == ST_SWEEP && enable_i) begin
            // The step also lands on the edge that leaves SWEEP, so a clamp there is kept.
            if (lo_x >= hi_x) begin
                acc_d = lo_x[AW-1:0];
            end else if (MODE == 1) begin
                acc_d = (sum_x >= hi_x) ? lo_x[AW-1:0] : sum_x[AW-1:0];
            end else if (up_q) begin
                if (sum_x >= hi_x) begin
                    acc_d = hi_x[AW-1:0];
                    up_d  = 1'b0;
                end else begin
                    acc_d = sum_x[AW-1:0];
                end
            end else begin
                if (dif_x <= lo_x) begin
                    acc_d = lo_x[AW-1:0];
                    up_d  = 1'b1;
                end else begin
                    acc_d = dif_x[AW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            acc_q  <= '0;
            up_q   <= 1'b1;
            cnt_q  <= '0;
            act_q  <= 1'b0;
            rst_q  <= 1'b0;
`ifdef RELOCK_HOLDOFF_EN
            hold_q <= '0;
`endif
        end else begin
            acc_q  <= acc_d;
            up_q   <= up_d;
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            rst_q  <= rst_d;
`ifdef RELOCK_HOLDOFF_EN
            hold_q <= hold_d;
`endif
        end
    end

    assign sweep_o      = acc_q[AW-1:SW];
    assign sweep_act_o  = act_q;
    assign int_rst_o    = rst_q;
    assign state_o      = state_q;
    assign relock_cnt_o = cnt_q;

endmodule

// File: doc/red_pitaya_relock_sweep.md
RED_PITAYA_RELOCK_SWEEP -- requirements
Module: red_pitaya_relock_sweep

Interface
REQ-001 Parameter DW, 14, signed sweep output and bound width.
REQ-002 Parameter RW, 12, unsigned relock monitor input width.
REQ-003 Parameter SW, 24, unsigned sweep step width; accumulator width DW+SW, sweep_o = accumulator[DW+SW-1:SW].
REQ-004 Parameter MODE, 0, 0 = triangle sweep, 1 = sawtooth sweep.
REQ-005 clk_i  in  1  system clock; single clock domain.
REQ-006 rstn_i  in  1  reset, asynchronous, active-low.
REQ-007 enable_i  in  1  relock function enable.
REQ-008 relock_i  in  RW  monitored lock-quality signal, unsigned.
REQ-009 win_min_i / win_max_i  in  RW  lock window bounds, unsigned, inclusive.
REQ-010 holdoff_i  in  16  cycles out-of-lock before sweep starts.
REQ-011 step_i  in  SW  accumulator increment per cycle.
REQ-012 out_lo_i / out_hi_i  in  DW  signed sweep bounds.
REQ-013 railed_i  in  2  limiter rail flags; nonzero = output railed, treated as out of lock.
REQ-014 sweep_o  out  DW  signed sweep value.
REQ-015 sweep_act_o  out  1  high while in SWEEP; selects sweep_o over PID output.
REQ-016 int_rst_o  out  1  one-cycle integrator reset pulse.
REQ-017 state_o  out  2  current state encoding: IDLE=0, LOCKED=1, HOLDOFF=2, SWEEP=3.
REQ-018 relock_cnt_o  out  16  number of SWEEP entries, saturating at 16'hFFFF.

Function
REQ-019 in_lock = (win_min_i <= relock_i <= win_max_i) && railed_i == 0, evaluated combinationally on each cycle's inputs; win_min_i > win_max_i gives in_lock = 0.
REQ-020 All outputs are registered; state and outputs change on the clock edge following the causing input.
REQ-021 enable_i low forces IDLE on the next edge from any state; sweep_act_o = 0, no int_rst_o pulse.
REQ-022 IDLE: on enable_i high, go to LOCKED if in_lock, else HOLDOFF.
REQ-023 LOCKED: !in_lock goes to HOLDOFF with hold counter cleared to 0.
REQ-024 HOLDOFF: in_lock returns to LOCKED; otherwise counter increments; when counter == holdoff_i, go to SWEEP; holdoff_i = 0 gives SWEEP on the next edge.
REQ-025 On SWEEP entry: int_rst_o = 1 for exactly that cycle; accumulator loaded with out_lo_i << SW; direction = up; relock_cnt_o increments.
REQ-026 SWEEP, MODE 0: each cycle accumulator +/- step_i; result >= out_hi_i clamps to out_hi_i and direction flips to down; result <= out_lo_i clamps to out_lo_i and direction flips to up.
REQ-027 SWEEP, MODE 1: upward only; result >= out_hi_i reloads out_lo_i << SW.
REQ-028 Accumulator arithmetic uses DW+SW+1 bits so that overflow never wraps before clamping.
REQ-029 out_lo_i >= out_hi_i: sweep_o holds out_lo_i for the whole of SWEEP.
REQ-030 SWEEP: in_lock goes to LOCKED on the next edge; sweep_act_o drops the same edge; sweep_o holds its last value until the next SWEEP entry.
REQ-031 A step that reaches a bound on the same cycle in_lock returns: the state goes to LOCKED and the clamped value is held.
REQ-032 step_i = 0 in SWEEP: sweep_o stays constant; state handling is unchanged.

Reset
REQ-033 rstn_i low asynchronously sets: state IDLE, sweep_o = 0, sweep_act_o = 0, int_rst_o = 0, relock_cnt_o = 0, hold counter = 0, accumulator = 0, direction = up.
REQ-034 Reset asserted mid-SWEEP aborts the sweep immediately with no further int_rst_o pulse.
REQ-035 After release, operation resumes from IDLE on the first clock edge.

Configuration
REQ-036 Macro RELOCK_HOLDOFF_EN defined: HOLDOFF state and hold counter are implemented as in REQ-023/024.
REQ-037 Macro not defined: no HOLDOFF state; LOCKED/IDLE with !in_lock go directly to SWEEP on the next edge; holdoff_i is ignored; state_o never equals 2.

Verification
REQ-038 Window 500..4000, relock_i = 1000, enable high -> LOCKED in 1 cycle, sweep_act_o = 0, no int_rst_o pulse.
REQ-039 relock_i drops to 0, holdoff_i = 100 (macro on) -> SWEEP entered 101 cycles later, single int_rst_o pulse, relock_cnt_o = 1.
REQ-040 MODE 0, lo = 0, hi = 4000, step_i = 1<<SW -> sweep_o ramps 0..4000, clamps at 4000, descends to 0, repeats; period 8000 cycles.
REQ-041 relock_i = 3000 during SWEEP -> LOCKED next edge, sweep_act_o = 0, sweep_o frozen.
REQ-042 railed_i = 2'b01 with relock_i in window -> leaves LOCKED; reset pulse mid-SWEEP -> all outputs zero, state IDLE.
REQ-043 Macro off, relock_i out of window -> SWEEP next edge; state_o never equals 2.
